// File: rtl/route_pkg.sv
// Shared types and sizing for the route query master and its engine link.
package route_pkg;

    localparam int unsigned STN_W             = 4;
    localparam int unsigned EDGE_W            = 2 * STN_W;
    localparam int unsigned LAT_W             = 15;
    localparam int unsigned TIMEOUT_DEFAULT   = 30000;
    localparam int unsigned MAX_EDGES_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        CHECK,
        DONE
    } state_e;

    typedef struct packed {
        logic [STN_W-1:0] src;
        logic [STN_W-1:0] dst;
    } edge_t;

endpackage

// File: rtl/route_query_master_if.sv
// Engine-side link of the route query protocol: edge stream out, one-cycle cost reply back.
interface route_query_master_if;
    import route_pkg::*;

    logic             in_valid;
    logic [STN_W-1:0] source;
    logic [STN_W-1:0] destination;
    logic             out_valid;
    logic [STN_W-1:0] cost;

    modport master (
        output in_valid,
        output source,
        output destination,
        input  out_valid,
        input  cost
    );

    modport slave (
        input  in_valid,
        input  source,
        input  destination,
        output out_valid,
        output cost
    );

endinterface

// File: rtl/edge_fifo.sv
// Synchronous FIFO holding the host-loaded edge list; clear empties it in one cycle.
module edge_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/route_query_master.sv
// Initiator for the station/edge protocol: streams a host-loaded edge list to the path-cost
// engine, waits for its one-cycle reply and reports cost, reply latency and protocol errors.
module route_query_master
    import route_pkg::*;
#(
    parameter int unsigned MAX_EDGES = MAX_EDGES_DEFAULT,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [STN_W-1:0]     wr_src,
    input  logic [STN_W-1:0]     wr_dst,
    input  logic                 start,
    output logic                 full,
    output logic                 busy,
    output logic                 done,
    output logic [STN_W-1:0]     result_cost,
    output logic [LAT_W-1:0]     latency,
    output logic                 timeout_err,
    output logic                 proto_err,
    route_query_master_if.master eng
);

    localparam int unsigned      CNT_W    = $clog2(MAX_EDGES + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [STN_W-1:0] cost_q, cost_d;
    logic             terr_q, terr_d;
    logic             perr_q, perr_d;

    edge_t            wr_edge, head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push, fifo_pop, fifo_clear, fifo_empty;
    logic             start_ok, sending;

    assign wr_edge   = '{src: wr_src, dst: wr_dst};
    assign fifo_push = wr_en && (state_q == IDLE) && !full;
    // A same-cycle push already counts, so start sees the buffer as non-empty.
    assign start_ok  = start && (state_q == IDLE) && (!fifo_empty || fifo_push);

    edge_fifo #(
        .DEPTH (MAX_EDGES),
        .WIDTH (EDGE_W)
    ) u_edge_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wr_edge),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        lat_d      = lat_q;
        cost_d     = cost_q;
        terr_d     = terr_q;
        perr_d     = perr_q;
        fifo_pop   = 1'b0;
        fifo_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = SEND;
                    terr_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            SEND: begin
                fifo_pop  = 1'b1;
                lat_cnt_d = '0;
                if (fifo_count <= CNT_W'(1)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (eng.out_valid) begin
                    cost_d  = eng.cost;
                    lat_d   = lat_cnt_q;
                    state_d = CHECK;
                end else if (lat_cnt_q >= LAT_LAST) begin
                    // No reply: report saturated latency and a zero cost.
                    terr_d  = 1'b1;
                    cost_d  = '0;
                    lat_d   = LAT_LAST;
                    state_d = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (eng.out_valid) begin
                    perr_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                fifo_clear = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reply outside WAIT/CHECK is a protocol violation and is otherwise ignored.
        if (eng.out_valid && (state_q == IDLE || state_q == SEND || state_q == DONE)) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            lat_q     <= '0;
            cost_q    <= '0;
            terr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            lat_q     <= lat_d;
            cost_q    <= cost_d;
            terr_q    <= terr_d;
            perr_q    <= perr_d;
        end
    end

    // Outputs decode straight from the state register so reset clears them immediately.
    assign sending         = (state_q == SEND);
    assign eng.in_valid    = sending;
    assign eng.source      = sending ? head.src : '0;
    assign eng.destination = sending ? head.dst : '0;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign result_cost     = cost_q;
    assign latency         = lat_q;
    assign timeout_err     = terr_q;
    assign proto_err       = perr_q;

endmodule

// File: tb/tb_route_query_master.sv
// Self-checking bench for route_query_master: table vectors, hand corner cases, random traffic.
module tb_route_query_master;
    import route_pkg::*;

    localparam int MAX_EDGES = 32;
    localparam int TIMEOUT   = 100;
    localparam int MAX_CYC   = 300;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [STN_W-1:0] wr_src;
    logic [STN_W-1:0] wr_dst;
    logic             start;
    logic             full;
    logic             busy;
    logic             done;
    logic [STN_W-1:0] result_cost;
    logic [LAT_W-1:0] latency;
    logic             timeout_err;
    logic             proto_err;

    route_query_master_if bus ();

    route_query_master #(
        .MAX_EDGES (MAX_EDGES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_src      (wr_src),
        .wr_dst      (wr_dst),
        .start       (start),
        .full        (full),
        .busy        (busy),
        .done        (done),
        .result_cost (result_cost),
        .latency     (latency),
        .timeout_err (timeout_err),
        .proto_err   (proto_err),
        .eng         (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the edges the host has successfully loaded, in order.
    logic [7:0] model_q [$];

    typedef struct {
        int          n;
        logic [31:0] e;
        int          delay;
        int          hold;
        logic [3:0]  rc;
        logic [3:0]  exp_cost;
        int          exp_lat;
        logic        exp_terr;
        logic        exp_perr;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input int n, input logic [31:0] e, input int delay,
                                input int hold, input logic [3:0] rc, input logic [3:0] ec,
                                input int el, input logic et, input logic ep);
        vec_t v;
        v.n = n; v.e = e; v.delay = delay; v.hold = hold; v.rc = rc;
        v.exp_cost = ec; v.exp_lat = el; v.exp_terr = et; v.exp_perr = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_edge(input logic [7:0] e);
        wr_en  = 1'b1;
        wr_src = e[7:4];
        wr_dst = e[3:0];
        if (model_q.size() < MAX_EDGES) model_q.push_back(e);
        tick();
        wr_en = 1'b0;
    endtask

    // Launch one transaction and play the engine: reply `delay` WAIT cycles after the stream
    // ends (negative = never), holding out_valid for `hold` cycles.
    task automatic run_txn(input int delay, input int hold, input logic [3:0] rc,
                           input logic [3:0] exp_cost, input int exp_lat, input logic exp_terr,
                           input logic exp_perr, input bit noise, input bit co_write,
                           input logic [7:0] co_edge);
        int         n_exp, nvalid, widx, n_done;
        bit         seen, gap, dirty;
        logic [7:0] exp_e;
        if (co_write) begin
            wr_en  = 1'b1;
            wr_src = co_edge[7:4];
            wr_dst = co_edge[3:0];
            if (model_q.size() < MAX_EDGES) model_q.push_back(co_edge);
        end
        n_exp = model_q.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        nvalid = 0; widx = -1; n_done = 0; seen = 0; gap = 0; dirty = 0;
        for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
            if (cyc == 0) chk("busy_on_send", 32'(busy), 32'd1);
            if (done) begin
                n_done++;
                break;
            end
            if (bus.in_valid) begin
                if (widx >= 0) gap = 1;
                nvalid++;
                if (model_q.size() == 0) begin
                    chk("stream_extra_edge", 32'(nvalid), 32'(n_exp));
                end else begin
                    exp_e = model_q.pop_front();
                    chk("stream_edge", 32'({bus.source, bus.destination}), 32'(exp_e));
                end
                seen = 1;
            end else begin
                if (seen && widx < 0) widx = 0;
                if (bus.source !== 4'd0 || bus.destination !== 4'd0) dirty = 1;
            end
            bus.out_valid = (widx >= 0) && (delay >= 0) && (widx >= delay) &&
                            (widx < delay + hold);
            bus.cost = bus.out_valid ? rc : 4'($urandom);
            if (noise) begin
                wr_en  = 1'($urandom_range(0, 1));
                wr_src = 4'($urandom);
                wr_dst = 4'($urandom);
                start  = 1'($urandom_range(0, 1));
            end
            tick();
            if (widx >= 0) widx++;
        end
        bus.out_valid = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        model_q.delete();
        chk("done_seen", 32'(n_done), 32'd1);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("in_valid_count", 32'(nvalid), 32'(n_exp));
        chk("in_valid_contiguous", 32'(gap), 32'd0);
        chk("bus_zero_when_idle", 32'(dirty), 32'd0);
        chk("result_cost", 32'(result_cost), 32'(exp_cost));
        if (exp_lat >= 0) chk("latency", 32'(latency), 32'(exp_lat));
        chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
        chk("proto_err", 32'(proto_err), 32'(exp_perr));
        chk("full_after_done", 32'(full), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n, delay, hold;
        logic [3:0] rc;
        bit         co;

        rst_n = 1'b0; wr_en = 1'b0; wr_src = '0; wr_dst = '0; start = 1'b0;
        bus.out_valid = 1'b0; bus.cost = '0;

        tick();
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cost", 32'(result_cost), 32'd0);
        chk("rst_latency", 32'(latency), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        chk("rst_in_valid", 32'(bus.in_valid), 32'd0);
        chk("rst_bus", 32'({bus.source, bus.destination}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Stray reply while idle flags a protocol error; the next start clears it.
        bus.out_valid = 1'b1;
        tick();
        bus.out_valid = 1'b0;
        chk("perr_idle_reply", 32'(proto_err), 32'd1);
        chk("idle_reply_no_start", 32'(busy), 32'd0);

        vecs[0] = mk(3, 32'h005F1501,  4, 1,  3,  3,  4, 1'b0, 1'b0);
        vecs[1] = mk(1, 32'h00000092,  0, 1, 10, 10,  0, 1'b0, 1'b0);
        vecs[2] = mk(2, 32'h0000A7C3, -1, 1,  6,  0, -1, 1'b1, 1'b0);
        vecs[3] = mk(4, 32'h8E2D4B6F,  2, 2,  7,  7,  2, 1'b0, 1'b1);
        vecs[4] = mk(1, 32'h000000FF, 99, 1, 15, 15, 99, 1'b0, 1'b0);
        vecs[5] = mk(2, 32'h00001100,  1, 1,  0,  0,  1, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vecs[i].n; j++) push_edge(vecs[i].e[8*j +: 8]);
            run_txn(vecs[i].delay, vecs[i].hold, vecs[i].rc, vecs[i].exp_cost,
                    vecs[i].exp_lat, vecs[i].exp_terr, vecs[i].exp_perr, 1'b0, 1'b0, 8'h00);
        end

        // Edge written in the same cycle as start is part of the stream.
        run_txn(3, 1, 4'd9, 4'd9, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h4A);

        // Fill to capacity, overflow push dropped, host noise during SEND ignored.
        for (int k = 0; k < 33; k++) begin
            push_edge(8'($urandom));
            if (k == 30) chk("full_at_31", 32'(full), 32'd0);
            if (k == 31) chk("full_at_32", 32'(full), 32'd1);
            if (k == 32) chk("full_after_33", 32'(full), 32'd1);
        end
        run_txn(3, 1, 4'd5, 4'd5, 3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Asynchronous reset while the second of five edges is on the bus.
        for (int k = 0; k < 5; k++) push_edge(8'($urandom));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_send_valid", 32'(bus.in_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_in_valid", 32'(bus.in_valid), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_bus", 32'({bus.source, bus.destination}), 32'd0);
        tick();
        rst_n = 1'b1;
        model_q.delete();
        tick();
        chk("rst_async_full", 32'(full), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_empty_ignored", 32'(busy), 32'd0);
        tick();
        chk("start_empty_still_idle", 32'(busy), 32'd0);
        push_edge(8'h3C);
        run_txn(0, 1, 4'd2, 4'd2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Random traffic against the queue model.
        for (int t = 0; t < 20; t++) begin
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) push_edge(8'($urandom));
            delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 40));
            hold  = ($urandom_range(0, 4) == 0) ? 2 : 1;
            rc    = 4'($urandom);
            co    = ($urandom_range(0, 3) == 0);
            run_txn(delay, hold, rc, (delay < 0) ? 4'd0 : rc, delay, delay < 0,
                    (delay >= 0) && (hold > 1), (t % 2) == 1, co, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
